ball_tracker: RTL and testbench

BALL_TRACKER -- requirements
Module: ball_tracker

---
 rtl/ball_pkg.sv | 30 +++
 rtl/ball_intercept_predictor.sv | 107 ++++++++++
 rtl/ball_tracker.sv | 212 +++++++++++++++++++++
 tb/tb_ball_tracker.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ball_pkg.sv
// Grid constants, coordinate/velocity types and tracker state encoding shared by the tracker.
// No timing or flow control: types and pure functions only.
package ball_pkg;

  localparam int GRID_COLS = 40;
  localparam int GRID_ROWS = 30;

  typedef logic [5:0]        grid_x_t;
  typedef logic [4:0]        grid_y_t;
  typedef logic signed [4:0] vel_t;
  typedef logic signed [7:0] wide_t;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_COAST   = 2'd3
  } trk_state_t;

  function automatic wide_t sext_vel(input vel_t v);
    return {{3{v[4]}}, v};
  endfunction

  function automatic wide_t clamp_wide(input wide_t v, input wide_t hi);
    if (v < 8'sd0) return 8'sd0;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/ball_intercept_predictor.sv
// Steps the ball trajectory one frame per cycle, folding off the side walls, until it reaches the paddle row.
// Result one cycle after start plus one per step; start restarts a run, abort drops it silently.
module ball_intercept_predictor
  import ball_pkg::*;
#(
  parameter int COLS       = GRID_COLS,
  parameter int PADDLE_ROW = 29
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [5:0] start_x,
  input  logic [4:0] start_y,
  input  logic [4:0] start_vx,
  input  logic [4:0] start_vy,
  output logic       busy,
  output logic       done,
  output logic [5:0] result_x
);

  localparam wide_t      X_MAX   = wide_t'(COLS - 1);
  localparam wide_t      X_FOLD  = wide_t'(2 * (COLS - 1));
  localparam wide_t      ROW_END = wide_t'(PADDLE_ROW);
  localparam logic [5:0] X_RESET = 6'(COLS / 2);

  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [5:0] res_q, res_d;
  wide_t      px_q, px_d, py_q, py_d, vx_q, vx_d, vy_q, vy_d;
  wide_t      step_x, step_y, step_vx, init_y;

  // Reflection is a single fold: a per-frame move never exceeds the grid width.
  always_comb begin
    step_x  = px_q + vx_q;
    step_y  = py_q + vy_q;
    step_vx = vx_q;
    if (step_x < 8'sd0) begin
      step_x  = -step_x;
      step_vx = -step_vx;
    end
    if (step_x > X_MAX) begin
      step_x  = X_FOLD - step_x;
      step_vx = -step_vx;
    end
  end

  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    res_d  = res_q;
    px_d   = px_q;
    py_d   = py_q;
    vx_d   = vx_q;
    vy_d   = vy_q;
    init_y = wide_t'({3'b000, start_y});
    if (abort) begin
      busy_d = 1'b0;
    end else if (start) begin
      px_d = wide_t'({2'b00, start_x});
      py_d = init_y;
      vx_d = sext_vel(start_vx);
      vy_d = sext_vel(start_vy);
      if (init_y >= ROW_END) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        res_d  = start_x;
      end else begin
        busy_d = 1'b1;
      end
    end else if (busy_q) begin
      px_d = step_x;
      py_d = step_y;
      vx_d = step_vx;
      if (step_y >= ROW_END) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        res_d  = step_x[5:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      res_q  <= X_RESET;
      px_q   <= '0;
      py_q   <= '0;
      vx_q   <= '0;
      vy_q   <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      res_q  <= res_d;
      px_q   <= px_d;
      py_q   <= py_d;
      vx_q   <= vx_d;
      vy_q   <= vy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result_x = res_q;

endmodule

// File: rtl/ball_tracker.sv
// Locks onto per-frame ball detections, tracks/coasts them and launches the paddle-row intercept predictor.
// All outputs update one cycle after the BALL_VALID strobe; no backpressure, one strobe per frame assumed.
module ball_tracker
  import ball_pkg::*;
#(
  parameter int COLS       = GRID_COLS,
  parameter int ROWS       = GRID_ROWS,
  parameter int MIN_COUNT  = 8,
  parameter int ACQ_HITS   = 3,
  parameter int MAX_JUMP   = 4,
  parameter int MAX_MISS   = 5,
  parameter int PADDLE_ROW = 29
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       ENABLE,
  input  logic       BALL_VALID,
  input  logic [5:0] BALL_X,
  input  logic [4:0] BALL_Y,
  input  logic [7:0] BALL_COUNT,
  output logic [5:0] TRACK_X,
  output logic [4:0] TRACK_Y,
  output logic [4:0] VEL_X,
  output logic [4:0] VEL_Y,
  output logic       LOCKED,
  output logic [5:0] PRED_X,
  output logic       PRED_VALID
);

  localparam logic [7:0] MIN_CNT  = 8'(MIN_COUNT);
  localparam logic [5:0] COL_LIM  = 6'(COLS);
  localparam logic [4:0] ROW_LIM  = 5'(ROWS);
  localparam logic [3:0] HITS_LIM = 4'(ACQ_HITS);
  localparam logic [3:0] MISS_LIM = 4'(MAX_MISS);
  localparam wide_t      JUMP_LIM = wide_t'(MAX_JUMP);
  localparam wide_t      X_MAX    = wide_t'(COLS - 1);
  localparam wide_t      Y_MAX    = wide_t'(ROWS - 1);

  trk_state_t state_q, state_d;
  logic [3:0] hits_q, hits_d, misses_q, misses_d, hits_nxt, miss_nxt;
  grid_x_t    track_x_q, track_x_d;
  grid_y_t    track_y_q, track_y_d;
  vel_t       vel_x_q, vel_x_d, vel_y_q, vel_y_d;
  logic       locked_q, locked_d, start_q, start_d;

  logic       det, near, lock_reached, enter_search;
  wide_t      dx, dy, adx, ady, ext_x, ext_y;
  logic       pred_start, pred_abort, pred_busy;

  always_comb begin
    det   = BALL_VALID && (BALL_COUNT >= MIN_CNT) && (BALL_X < COL_LIM) && (BALL_Y < ROW_LIM);
    dx    = wide_t'({2'b00, BALL_X}) - wide_t'({2'b00, track_x_q});
    dy    = wide_t'({3'b000, BALL_Y}) - wide_t'({3'b000, track_y_q});
    adx   = dx[7] ? -dx : dx;
    ady   = dy[7] ? -dy : dy;
    near  = (adx <= JUMP_LIM) && (ady <= JUMP_LIM);
    ext_x = clamp_wide(wide_t'({2'b00, track_x_q}) + sext_vel(vel_x_q), X_MAX);
    ext_y = clamp_wide(wide_t'({3'b000, track_y_q}) + sext_vel(vel_y_q), Y_MAX);
    hits_nxt     = hits_q + 4'd1;
    miss_nxt     = misses_q + 4'd1;
    lock_reached = hits_nxt >= HITS_LIM;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_SEARCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!ENABLE) begin
      state_d = ST_SEARCH;
    end else if (BALL_VALID) begin
      case (state_q)
        ST_SEARCH:  if (det) state_d = ST_ACQUIRE;
        ST_ACQUIRE: begin
          if (!det)                      state_d = ST_SEARCH;
          else if (near && lock_reached) state_d = ST_TRACK;
        end
        ST_TRACK:   if (!(det && near)) state_d = ST_COAST;
        ST_COAST: begin
          if (det && near)          state_d = ST_TRACK;
          else if (miss_nxt >= MISS_LIM) state_d = ST_SEARCH;
        end
        default:    state_d = ST_SEARCH;
      endcase
    end
  end

  assign enter_search = (state_d == ST_SEARCH) && (state_q != ST_SEARCH);

  // start_d marks every position update that lands in TRACK; the predictor picks it up next cycle.
  always_comb begin
    track_x_d = track_x_q;
    track_y_d = track_y_q;
    vel_x_d   = vel_x_q;
    vel_y_d   = vel_y_q;
    hits_d    = hits_q;
    misses_d  = misses_q;
    start_d   = 1'b0;
    if (ENABLE && BALL_VALID) begin
      case (state_q)
        ST_SEARCH: begin
          if (det) begin
            track_x_d = BALL_X;
            track_y_d = BALL_Y;
            hits_d    = 4'd1;
          end
        end
        ST_ACQUIRE: begin
          if (det && near) begin
            vel_x_d   = dx[4:0];
            vel_y_d   = dy[4:0];
            track_x_d = BALL_X;
            track_y_d = BALL_Y;
            hits_d    = hits_nxt;
            start_d   = lock_reached;
          end else if (det) begin
            track_x_d = BALL_X;
            track_y_d = BALL_Y;
            hits_d    = 4'd1;
          end
        end
        ST_TRACK: begin
          if (det && near) begin
            vel_x_d   = dx[4:0];
            vel_y_d   = dy[4:0];
            track_x_d = BALL_X;
            track_y_d = BALL_Y;
            start_d   = 1'b1;
          end else begin
            track_x_d = ext_x[5:0];
            track_y_d = ext_y[4:0];
            misses_d  = 4'd1;
          end
        end
        ST_COAST: begin
          if (det && near) begin
            track_x_d = BALL_X;
            track_y_d = BALL_Y;
            misses_d  = 4'd0;
            start_d   = 1'b1;
          end else begin
            track_x_d = ext_x[5:0];
            track_y_d = ext_y[4:0];
            misses_d  = miss_nxt;
          end
        end
        default: ;
      endcase
    end
    if (state_d == ST_SEARCH) begin
      hits_d   = 4'd0;
      misses_d = 4'd0;
    end
    if (enter_search) begin
      vel_x_d = '0;
      vel_y_d = '0;
    end
    locked_d = (state_d == ST_TRACK) || (state_d == ST_COAST);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      track_x_q <= '0;
      track_y_q <= '0;
      vel_x_q   <= '0;
      vel_y_q   <= '0;
      hits_q    <= '0;
      misses_q  <= '0;
      locked_q  <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      track_x_q <= track_x_d;
      track_y_q <= track_y_d;
      vel_x_q   <= vel_x_d;
      vel_y_q   <= vel_y_d;
      hits_q    <= hits_d;
      misses_q  <= misses_d;
      locked_q  <= locked_d;
      start_q   <= start_d;
    end
  end

  // A ball moving up or sideways never reaches the paddle row, so only downward motion launches a run.
  assign pred_start = start_q && ENABLE && (vel_y_q > 5'sd0);
  assign pred_abort = pred_busy && (!ENABLE || enter_search);

  ball_intercept_predictor #(
    .COLS       (COLS),
    .PADDLE_ROW (PADDLE_ROW)
  ) u_pred (
    .clk      (CLK),
    .rst_n    (RST_N),
    .start    (pred_start),
    .abort    (pred_abort),
    .start_x  (track_x_q),
    .start_y  (track_y_q),
    .start_vx (vel_x_q),
    .start_vy (vel_y_q),
    .busy     (pred_busy),
    .done     (PRED_VALID),
    .result_x (PRED_X)
  );

  assign TRACK_X = track_x_q;
  assign TRACK_Y = track_y_q;
  assign VEL_X   = vel_x_q;
  assign VEL_Y   = vel_y_q;
  assign LOCKED  = locked_q;

endmodule

// File: tb/tb_ball_tracker.sv
// Directed bench for ball_tracker: lock, prediction, wall bounce, loss, restart, enable and reset cases.
module tb_ball_tracker;

  logic       CLK = 1'b0;
  logic       RST_N, ENABLE, BALL_VALID;
  logic [5:0] BALL_X;
  logic [4:0] BALL_Y;
  logic [7:0] BALL_COUNT;
  logic [5:0] TRACK_X, PRED_X;
  logic [4:0] TRACK_Y, VEL_X, VEL_Y;
  logic       LOCKED, PRED_VALID;

  int n_total = 0;
  int n_pass  = 0;

  always #5 CLK = ~CLK;

  ball_tracker dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .ENABLE     (ENABLE),
    .BALL_VALID (BALL_VALID),
    .BALL_X     (BALL_X),
    .BALL_Y     (BALL_Y),
    .BALL_COUNT (BALL_COUNT),
    .TRACK_X    (TRACK_X),
    .TRACK_Y    (TRACK_Y),
    .VEL_X      (VEL_X),
    .VEL_Y      (VEL_Y),
    .LOCKED     (LOCKED),
    .PRED_X     (PRED_X),
    .PRED_VALID (PRED_VALID)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  // One-cycle strobe; returns #1 after the edge that consumed it.
  task automatic strobe(input int x, input int y, input int cnt);
    @(posedge CLK); #1;
    BALL_VALID = 1'b1;
    BALL_X     = 6'(x);
    BALL_Y     = 5'(y);
    BALL_COUNT = 8'(cnt);
    @(posedge CLK); #1;
    BALL_VALID = 1'b0;
  endtask

  task automatic wait_pred(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge CLK); #1;
      if (PRED_VALID) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic count_pulses(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      if (PRED_VALID) cnt++;
    end
  endtask

  initial begin
    bit seen;
    int np;

    RST_N      = 1'b0;
    ENABLE     = 1'b1;
    BALL_VALID = 1'b0;
    BALL_X     = '0;
    BALL_Y     = '0;
    BALL_COUNT = '0;
    #12;
    check("rst_track_x", TRACK_X, 0);
    check("rst_track_y", TRACK_Y, 0);
    check("rst_vel_x", VEL_X, 0);
    check("rst_vel_y", VEL_Y, 0);
    check("rst_locked", LOCKED, 0);
    check("rst_pred_x", PRED_X, 20);
    check("rst_pred_valid", PRED_VALID, 0);
    @(posedge CLK); #1;
    RST_N = 1'b1;

    // Detection qualification in SEARCH
    strobe(45, 3, 20);
    check("oob_col_ignored", TRACK_X, 0);
    strobe(5, 3, 7);
    check("low_count_ignored", TRACK_X, 0);
    strobe(5, 3, 8);
    check("min_count_loads_x", TRACK_X, 5);
    check("min_count_loads_y", TRACK_Y, 3);
    check("acquire_unlocked", LOCKED, 0);

    // Far jump restarts acquisition, then three near hits lock
    strobe(10, 5, 20);
    check("far_restart_x", TRACK_X, 10);
    check("far_restart_unlocked", LOCKED, 0);
    strobe(11, 6, 20);
    check("acq2_unlocked", LOCKED, 0);
    strobe(12, 7, 20);
    check("lock_locked", LOCKED, 1);
    check("lock_vel_x", VEL_X, 1);
    check("lock_vel_y", VEL_Y, 1);
    check("lock_track_x", TRACK_X, 12);
    check("lock_track_y", TRACK_Y, 7);
    wait_pred(60, seen);
    check("pred1_seen", seen, 1);
    check("pred1_x", PRED_X, 34);
    count_pulses(5, np);
    check("pred1_single_pulse", np, 0);

    // Loss: five misses coast then drop the lock
    for (int k = 1; k <= 5; k++) begin
      strobe(0, 0, 0);
      check($sformatf("coast%0d_x", k), TRACK_X, 12 + k);
      check($sformatf("coast%0d_y", k), TRACK_Y, 7 + k);
      check($sformatf("coast%0d_locked", k), LOCKED, (k < 5) ? 1 : 0);
    end
    check("lost_vel_x", VEL_X, 0);
    check("lost_vel_y", VEL_Y, 0);
    check("lost_pred_hold", PRED_X, 34);

    // Wall bounce
    strobe(31, 14, 20);
    strobe(34, 17, 20);
    strobe(37, 20, 20);
    check("bounce_locked", LOCKED, 1);
    check("bounce_vel_x", VEL_X, 3);
    check("bounce_vel_y", VEL_Y, 3);
    wait_pred(60, seen);
    check("bounce_seen", seen, 1);
    check("bounce_pred_x", PRED_X, 32);

    // ENABLE low beats a simultaneous strobe
    ENABLE = 1'b0;
    strobe(38, 21, 20);
    check("disable_unlocked", LOCKED, 0);
    check("disable_track_hold", TRACK_X, 37);
    check("disable_vel_clear", VEL_X, 0);
    ENABLE = 1'b1;

    // Acquire restart; horizontal lock must not launch a prediction
    strobe(10, 5, 20);
    strobe(20, 5, 20);
    check("restart2_unlocked", LOCKED, 0);
    check("restart2_x", TRACK_X, 20);
    strobe(21, 5, 20);
    check("restart3_unlocked", LOCKED, 0);
    strobe(22, 5, 20);
    check("restart4_locked", LOCKED, 1);
    check("restart4_vel_y", VEL_Y, 0);
    count_pulses(30, np);
    check("flat_no_pred", np, 0);
    check("flat_pred_hold", PRED_X, 32);

    // Reset in the middle of a prediction run
    strobe(23, 6, 20);
    check("rerun_vel_y", VEL_Y, 1);
    repeat (5) @(posedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    check("midrst_pred_valid", PRED_VALID, 0);
    check("midrst_pred_x", PRED_X, 20);
    check("midrst_locked", LOCKED, 0);
    check("midrst_track_x", TRACK_X, 0);
    check("midrst_vel_y", VEL_Y, 0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    count_pulses(40, np);
    check("midrst_no_pulse", np, 0);

    // Already at the paddle row: zero-step result one cycle after start
    strobe(10, 25, 20);
    strobe(11, 27, 20);
    strobe(12, 29, 20);
    check("row_locked", LOCKED, 1);
    check("row_vel_y", VEL_Y, 2);
    @(posedge CLK); #1;
    check("row_pred_valid", PRED_VALID, 1);
    check("row_pred_x", PRED_X, 12);
    @(posedge CLK); #1;
    check("row_pulse_ends", PRED_VALID, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
